// File: rtl/priority_cd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : priority_cd_pkg
// Description : Shared occupancy-state type and parameter check for the
//               index-to-one-hot grant buffer.
// Revision    : 1.0
// ============================================================================
package priority_cd_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  localparam int c_fifo_depth = 2;

  function automatic bit onehot_width_ok(input int width);
    return width >= 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_dec.sv
`default_nettype none
// ============================================================================
// Module      : onehot_dec
// Description : Combinational binary-index to one-hot decoder with an
//               out-of-range flag for non-power-of-two widths.
// Revision    : 1.0
// ============================================================================
module onehot_dec #(
  parameter int  OUT_WIDTH = 8,
  localparam int IN_WIDTH  = $clog2(OUT_WIDTH)
) (
  input  logic                 i_en,
  input  logic [IN_WIDTH-1:0]  i_idx,
  output logic [OUT_WIDTH-1:0] o_onehot,
  output logic                 o_err
);

  // One extra bit so OUT_WIDTH itself is representable for the range compare.
  localparam logic [IN_WIDTH:0] c_limit = (IN_WIDTH + 1)'(OUT_WIDTH);

  logic [IN_WIDTH:0] w_idx_ext;
  logic              w_in_range;

  always_comb begin
    w_idx_ext  = {1'b0, i_idx};
    w_in_range = (w_idx_ext < c_limit);
    o_err      = i_en && !w_in_range;
    o_onehot   = '0;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      o_onehot[i] = i_en && (w_idx_ext == (IN_WIDTH + 1)'(i));
    end
  end

endmodule
`default_nettype wire

// File: rtl/priority_dc_buf.sv
`default_nettype none
// ============================================================================
// Module      : priority_dc_buf
// Description : Decodes a handshaked index into a one-hot grant and holds it
//               in a 2-entry in-order skid FIFO with registered outputs.
// Revision    : 1.0
// ============================================================================
module priority_dc_buf
  import priority_cd_pkg::*;
#(
  parameter int  OUT_WIDTH = 8,
  localparam int IN_WIDTH  = $clog2(OUT_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_en,
  input  logic [IN_WIDTH-1:0]  in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 err
);

  localparam int c_entry_w = OUT_WIDTH + 1;

  generate
    if (!onehot_width_ok(OUT_WIDTH)) begin : g_width_check
      $error("priority_dc_buf: OUT_WIDTH must be at least 2");
    end
  endgenerate

  occ_e                 state_q, state_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [c_entry_w-1:0] mem_q [c_fifo_depth];
  logic [c_entry_w-1:0] mem_d [c_fifo_depth];

  logic [OUT_WIDTH-1:0] w_dec_onehot;
  logic                 w_dec_err;
  logic                 w_push;
  logic                 w_pop;

  onehot_dec #(
    .OUT_WIDTH (OUT_WIDTH)
  ) u_dec (
    .i_en     (in_en),
    .i_idx    (in),
    .o_onehot (w_dec_onehot),
    .o_err    (w_dec_err)
  );

  assign in_ready     = (state_q != FULL);
  assign out_valid    = (state_q != EMPTY);
  assign {err, out}   = mem_q[rd_ptr_q];

  always_comb begin
    w_push   = in_valid && in_ready;
    w_pop    = out_valid && out_ready;
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;

    // Push and pop never target the same slot: pointers only coincide in
    // EMPTY (no pop) and FULL (no push).
    if (w_push) begin
      mem_d[wr_ptr_q] = {w_dec_err, w_dec_onehot};
      wr_ptr_d        = ~wr_ptr_q;
    end
    // Clearing the popped slot keeps out/err at zero once the buffer drains.
    if (w_pop) begin
      mem_d[rd_ptr_q] = '0;
      rd_ptr_d        = ~rd_ptr_q;
    end

    case (state_q)
      EMPTY: begin
        if (w_push) state_d = ONE;
      end
      ONE: begin
        if (w_push && !w_pop)      state_d = FULL;
        else if (!w_push && w_pop) state_d = EMPTY;
      end
      FULL: begin
        if (w_pop) state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < c_fifo_depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < c_fifo_depth; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_priority_dc_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_priority_dc_buf
// Description : Directed and randomized checks of the grant buffer at widths 8 and 6.
// Revision    : 1.0
// ============================================================================
module tb_priority_dc_buf;

  logic       clk;
  logic       rst;

  logic       a_in_valid, a_in_ready, a_in_en, a_out_valid, a_out_ready, a_err;
  logic [2:0] a_in;
  logic [7:0] a_out;

  logic       b_in_valid, b_in_ready, b_in_en, b_out_valid, b_out_ready, b_err;
  logic [2:0] b_in;
  logic [5:0] b_out;

  int vectors;
  int miscompares;

  priority_dc_buf #(.OUT_WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_en     (a_in_en),
    .in        (a_in),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out       (a_out),
    .err       (a_err)
  );

  priority_dc_buf #(.OUT_WIDTH(6)) u_dut6 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_en     (b_in_en),
    .in        (b_in),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out       (b_out),
    .err       (b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_in_valid = 0; a_in_en = 0; a_in = '0; a_out_ready = 0;
    b_in_valid = 0; b_in_en = 0; b_in = '0; b_out_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    vectors++;
    if (a_out_valid !== 1'b0 || a_out !== 8'h00 || a_err !== 1'b0 || a_in_ready !== 1'b1) begin
      $display("FAIL reset_initial: valid=%b out=%h err=%b rdy=%b expected 0 00 0 1",
               a_out_valid, a_out, a_err, a_in_ready);
      miscompares++;
    end
    // Fill both entries, then reset between clock edges.
    a_in_valid = 1; a_in_en = 1; a_in = 3'd1;
    tick();
    a_in = 3'd2;
    tick();
    a_in_valid = 0;
    vectors++;
    if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out !== 8'h02) begin
      $display("FAIL reset_prefill: rdy=%b valid=%b out=%h expected 0 1 02",
               a_in_ready, a_out_valid, a_out);
      miscompares++;
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (a_out_valid !== 1'b0 || a_out !== 8'h00 || a_err !== 1'b0 || a_in_ready !== 1'b1) begin
      $display("FAIL reset_async: valid=%b out=%h err=%b rdy=%b expected 0 00 0 1",
               a_out_valid, a_out, a_err, a_in_ready);
      miscompares++;
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_sweep();
    logic [7:0] exp;
    a_out_ready = 1;
    a_in_valid  = 1;
    a_in_en     = 1;
    for (int i = 0; i < 8; i++) begin
      a_in = 3'(i);
      tick();
      exp = 8'h01 << i;
      vectors++;
      if (a_out_valid !== 1'b1 || a_out !== exp || a_err !== 1'b0) begin
        $display("FAIL sweep[%0d]: valid=%b out=%h err=%b expected 1 %h 0",
                 i, a_out_valid, a_out, a_err, exp);
        miscompares++;
      end
    end
    a_in_en = 0; a_in = 3'd3;
    tick();
    vectors++;
    if (a_out_valid !== 1'b1 || a_out !== 8'h00 || a_err !== 1'b0) begin
      $display("FAIL sweep_disabled: valid=%b out=%h err=%b expected 1 00 0",
               a_out_valid, a_out, a_err);
      miscompares++;
    end
    a_in_valid = 0;
    tick();
    vectors++;
    if (a_out_valid !== 1'b0 || a_out !== 8'h00) begin
      $display("FAIL sweep_drain: valid=%b out=%h expected 0 00", a_out_valid, a_out);
      miscompares++;
    end
  endtask

  task automatic test_backpressure();
    a_out_ready = 0;
    a_in_valid = 1; a_in_en = 1; a_in = 3'd5;
    tick();
    a_in = 3'd6;
    tick();
    vectors++;
    if (a_in_ready !== 1'b0 || a_out !== 8'h20) begin
      $display("FAIL bp_full: rdy=%b out=%h expected 0 20", a_in_ready, a_out);
      miscompares++;
    end
    a_in = 3'd7;
    tick();
    vectors++;
    if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out !== 8'h20) begin
      $display("FAIL bp_stall: rdy=%b valid=%b out=%h expected 0 1 20",
               a_in_ready, a_out_valid, a_out);
      miscompares++;
    end
    a_in_valid = 0;
    a_out_ready = 1;
    tick();
    vectors++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b1 || a_out !== 8'h40) begin
      $display("FAIL bp_second: rdy=%b valid=%b out=%h expected 1 1 40",
               a_in_ready, a_out_valid, a_out);
      miscompares++;
    end
    tick();
    vectors++;
    if (a_out_valid !== 1'b0 || a_out !== 8'h00) begin
      $display("FAIL bp_drop3rd: valid=%b out=%h expected 0 00", a_out_valid, a_out);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    a_out_ready = 0;
    a_in_valid = 1; a_in_en = 1; a_in = 3'd2;
    tick();
    vectors++;
    if (a_out !== 8'h04 || a_in_ready !== 1'b1) begin
      $display("FAIL b2b_one: out=%h rdy=%b expected 04 1", a_out, a_in_ready);
      miscompares++;
    end
    a_in = 3'd7;
    a_out_ready = 1;
    tick();
    vectors++;
    if (a_out_valid !== 1'b1 || a_out !== 8'h80 || a_in_ready !== 1'b1) begin
      $display("FAIL b2b_simul: valid=%b out=%h rdy=%b expected 1 80 1",
               a_out_valid, a_out, a_in_ready);
      miscompares++;
    end
    a_in_valid = 0;
    tick();
    vectors++;
    if (a_out_valid !== 1'b0 || a_out !== 8'h00) begin
      $display("FAIL b2b_empty: valid=%b out=%h expected 0 00", a_out_valid, a_out);
      miscompares++;
    end
  endtask

  task automatic test_range();
    logic [2:0] idx_tab [3];
    logic [5:0] out_tab [3];
    logic       err_tab [3];
    idx_tab = '{3'd6, 3'd7, 3'd5};
    out_tab = '{6'h00, 6'h00, 6'h20};
    err_tab = '{1'b1, 1'b1, 1'b0};
    b_out_ready = 1; b_in_valid = 1; b_in_en = 1;
    for (int i = 0; i < 3; i++) begin
      b_in = idx_tab[i];
      tick();
      vectors++;
      if (b_out_valid !== 1'b1 || b_out !== out_tab[i] || b_err !== err_tab[i]) begin
        $display("FAIL range[%0d]: valid=%b out=%h err=%b expected 1 %h %b",
                 i, b_out_valid, b_out, b_err, out_tab[i], err_tab[i]);
        miscompares++;
      end
    end
    b_in_valid = 0;
    tick();
    vectors++;
    if (b_out_valid !== 1'b0 || b_out !== 6'h00 || b_err !== 1'b0) begin
      $display("FAIL range_drain: valid=%b out=%h err=%b expected 0 00 0",
               b_out_valid, b_out, b_err);
      miscompares++;
    end
  endtask

  task automatic test_random();
    logic [8:0] q8 [$];
    logic [6:0] q6 [$];
    logic [8:0] e8;
    logic [6:0] e6;
    for (int c = 0; c < 10000; c++) begin
      a_in_valid  = 1'($urandom_range(0, 1));
      a_out_ready = 1'($urandom_range(0, 3) != 0);
      a_in_en     = 1'($urandom_range(0, 7) != 0);
      a_in        = 3'($urandom);
      b_in_valid  = 1'($urandom_range(0, 1));
      b_out_ready = 1'($urandom_range(0, 1));
      b_in_en     = 1'($urandom_range(0, 7) != 0);
      b_in        = 3'($urandom);
      #1;
      vectors++;
      if (a_out_valid !== (q8.size() != 0) || b_out_valid !== (q6.size() != 0)) begin
        $display("FAIL rnd_valid[%0d]: v8=%b n8=%0d v6=%b n6=%0d",
                 c, a_out_valid, q8.size(), b_out_valid, q6.size());
        miscompares++;
      end
      if (a_out_valid && a_out_ready && q8.size() != 0) begin
        e8 = q8.pop_front();
        vectors++;
        if ({a_err, a_out} !== e8 || $countones(a_out) > 1) begin
          $display("FAIL rnd_w8[%0d]: got %h expected %h", c, {a_err, a_out}, e8);
          miscompares++;
        end
      end
      if (b_out_valid && b_out_ready && q6.size() != 0) begin
        e6 = q6.pop_front();
        vectors++;
        if ({b_err, b_out} !== e6 || $countones(b_out) > 1) begin
          $display("FAIL rnd_w6[%0d]: got %h expected %h", c, {b_err, b_out}, e6);
          miscompares++;
        end
      end
      if (!a_out_valid && (a_out !== 8'h00 || a_err !== 1'b0)) begin
        $display("FAIL rnd_idle8[%0d]: out=%h err=%b expected 00 0", c, a_out, a_err);
        miscompares++;
      end
      if (a_in_valid && a_in_ready)
        q8.push_back(a_in_en ? {1'b0, 8'h01 << a_in} : 9'h000);
      if (b_in_valid && b_in_ready) begin
        if (!b_in_en)      q6.push_back(7'h00);
        else if (b_in > 5) q6.push_back(7'h40);
        else               q6.push_back({1'b0, 6'h01 << b_in});
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_sweep();
    test_backpressure();
    test_back_to_back();
    test_range();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
